// File: rtl/fa_cs303.sv
// Full adder with a bit-serial word adder engine (LSB first) sharing the same x/y/z inputs.
// Optional signed-overflow output ovf is enabled by defining FA_CS303_OVF_EN.
module fa_cs303 #(
    parameter int WIDTH = 8
) (
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             C,
    output logic             S,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    output logic [WIDTH-1:0] sum_word,
    output logic             cout_word,
    output logic             done,
    output logic             busy
`ifdef FA_CS303_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic             carry_q;
    logic [WIDTH-1:0] sh;
    logic [CNT_W-1:0] cnt;

    logic             cin;
    logic             sbit;
    logic             carry_n;
    logic             last;
    logic [WIDTH-1:0] sh_n;

    // The legacy full adder is purely combinational and never sees clock or reset.
    assign S = fa_sum(x, y, z);
    assign C = fa_maj(x, y, z);

    // A start bit takes its carry-in from z and abandons any partial word.
    assign cin     = start ? z : carry_q;
    assign sbit    = fa_sum(x, y, cin);
    assign carry_n = fa_maj(x, y, cin);
    assign last    = !start && (cnt == LAST_CNT);
    assign sh_n    = {sbit, sh[WIDTH-1:1]};
    assign busy    = (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q   <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
            sum_word  <= '0;
            cout_word <= 1'b0;
            done      <= 1'b0;
`ifdef FA_CS303_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (en) begin
                sh <= sh_n;
                if (last) begin
                    sum_word  <= sh_n;
                    cout_word <= carry_n;
                    done      <= 1'b1;
                    cnt       <= '0;
                    carry_q   <= 1'b0;
`ifdef FA_CS303_OVF_EN
                    // Carry into the MSB is cin of this final bit; carry out is carry_n.
                    ovf       <= cin ^ carry_n;
`endif
                end else begin
                    carry_q <= carry_n;
                    cnt     <= start ? CNT_W'(1) : cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fa_cs303.sv
// Directed self-checking bench for fa_cs303 (WIDTH=8): combinational adder and serial word engine.
module tb_fa_cs303;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             x, y, z, en, start;
    logic             C, S;
    logic [WIDTH-1:0] sum_word;
    logic             cout_word, done, busy;
`ifdef FA_CS303_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    fa_cs303 #(.WIDTH(WIDTH)) dut (
        .x(x), .y(y), .z(z), .C(C), .S(S),
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .sum_word(sum_word), .cout_word(cout_word), .done(done), .busy(busy)
`ifdef FA_CS303_OVF_EN
        , .ovf(ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic xb, input logic yb, input logic zb, input logic st, input logic e);
        @(negedge clk);
        x = xb; y = yb; z = zb; start = st; en = e;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Drives bits lo..hi of a and b; bit 0 carries start and z0 when use_start is set.
    task automatic send_bits(input logic [7:0] a, input logic [7:0] b, input logic z0,
                             input logic use_start, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(a[i], b[i], (i == 0) ? z0 : 1'b0, (i == 0) ? use_start : 1'b0, 1'b1);
        end
    endtask

    task automatic check_word(input string tag, input logic [7:0] exp_sum, input logic exp_cout,
                              input logic exp_ovf);
        idle();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_sum"}, 32'(sum_word), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(cout_word), 32'(exp_cout));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef FA_CS303_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) chk({tag, "_ovf_arg"}, 32'(exp_ovf), 32'd0);
`endif
        idle();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    logic [1:0] cs_exp [8];
    int         d0;

    initial begin
        cs_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        rst_n = 1'b0;
        x = 0; y = 0; z = 0; en = 0; start = 0;

        // Combinational sweep, held in reset to show C/S ignore it
        for (int v = 0; v < 8; v++) begin
            {x, y, z} = 3'(v);
            #1;
            chk($sformatf("comb_%0d", v), 32'({C, S}), 32'(cs_exp[v]));
            #9;
        end
        x = 0; y = 0; z = 0;
        #1;
        chk("rst_sum", 32'(sum_word), 32'd0);
        chk("rst_cout", 32'(cout_word), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0x5A + 0x3C
        d0 = done_seen;
        send_bits(8'h5A, 8'h3C, 1'b0, 1'b1, 0, 7);
        check_word("add5a3c", 8'h96, 1'b0, 1'b1);
        chk("add5a3c_npulse", 32'(done_seen - d0), 32'd1);

        // 0xFF + 0x01, then 0x00 + 0x00 with start carry-in
        send_bits(8'hFF, 8'h01, 1'b0, 1'b1, 0, 7);
        check_word("addff01", 8'h00, 1'b1, 1'b0);
        send_bits(8'h00, 8'h00, 1'b1, 1'b1, 0, 7);
        check_word("add00z1", 8'h01, 1'b0, 1'b0);

        // Carry cleared after completion: no-start word after a carry-out word
        send_bits(8'hFF, 8'h01, 1'b0, 1'b1, 0, 7);
        check_word("addff01b", 8'h00, 1'b1, 1'b0);
        send_bits(8'h03, 8'h01, 1'b0, 1'b0, 0, 7);
        check_word("nostart", 8'h04, 1'b0, 1'b0);

        // en gaps after bit 3, with start asserted while en is low
        d0 = done_seen;
        send_bits(8'h5A, 8'h3C, 1'b0, 1'b1, 0, 3);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("gap_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("gap_done", 32'(done), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("gap_busy2", 32'(busy), 32'd1);
        send_bits(8'h5A, 8'h3C, 1'b0, 1'b1, 4, 7);
        check_word("gap", 8'h96, 1'b0, 1'b1);
        chk("gap_npulse", 32'(done_seen - d0), 32'd1);

        // Asynchronous reset mid-word
        d0 = done_seen;
        send_bits(8'hFF, 8'hFF, 1'b1, 1'b1, 0, 4);
        idle();
        chk("mid_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_sum", 32'(sum_word), 32'd0);
        chk("arst_cout", 32'(cout_word), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
`ifdef FA_CS303_OVF_EN
        chk("arst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("arst_nopulse", 32'(done_seen - d0), 32'd0);
        send_bits(8'h12, 8'h34, 1'b0, 1'b0, 0, 7);
        check_word("post_rst", 8'h46, 1'b0, 1'b0);

        // start reasserted after bit 5 abandons the partial word
        d0 = done_seen;
        send_bits(8'hFF, 8'hFF, 1'b1, 1'b1, 0, 5);
        send_bits(8'h80, 8'h80, 1'b0, 1'b1, 0, 7);
        check_word("restart", 8'h00, 1'b1, 1'b1);
        chk("restart_npulse", 32'(done_seen - d0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fa_cs303.md
FA_CS303 -- requirements
Module: fa_cs303

Interface
REQ-001 Parameter WIDTH, default 8: number of bits per serial word; legal range 2..32.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port order in declaration: x, y, z, C, S first, then clk, rst_n, en, start, sum_word, cout_word, done, busy. This order keeps legacy positional 5-port instances valid.
REQ-004 clk  input  1  rising-edge clock for serial engine.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 x  input  1  addend bit A.
REQ-007 y  input  1  addend bit B.
REQ-008 z  input  1  carry-in; combinational path always, serial engine only on start.
REQ-009 C  output  1  combinational carry-out of x+y+z.
REQ-010 S  output  1  combinational sum of x+y+z.
REQ-011 en  input  1  serial bit valid this cycle.
REQ-012 start  input  1  first bit of a new serial word; qualified by en.
REQ-013 sum_word  output  WIDTH  last completed serial sum, registered.
REQ-014 cout_word  output  1  carry-out of last completed word, registered.
REQ-015 done  output  1  one-cycle pulse when sum_word/cout_word update.
REQ-016 busy  output  1  high while a word is partially received (bit count nonzero).

Function
REQ-017 S SHALL equal x^y^z and C SHALL equal (x&y)|(x&z)|(y&z), purely combinational, zero latency, independent of clk, rst_n, en, start.
REQ-018 Serial engine state: carry_q (1b), shift register sh (WIDTH b), bit counter cnt (0..WIDTH-1).
REQ-019 On rising clk with en=1: cin = start ? z : carry_q; bit = x^y^cin; carry_q <= maj(x,y,cin); sh <= {bit, sh[WIDTH-1:1]}. Bits arrive LSB first.
REQ-020 cnt <= start ? 1 : cnt+1 on an accepted bit.
REQ-021 When the accepted bit is the WIDTH-th of the word: sum_word <= {bit, sh[WIDTH-1:1]}; cout_word <= new carry; done <= 1 next cycle; cnt <= 0; carry_q <= 0.
REQ-022 done SHALL be 0 in every cycle not following a word completion.
REQ-023 en=0: all serial state held, start ignored, done=0.
REQ-024 start=1 while busy: partial word discarded, new word begins at bit 0 with cin=z; no done for the abandoned word.
REQ-025 First bit with cnt=0 and start=0 uses carry_q (0 after reset or completion).
REQ-026 WIDTH=1 word boundary never occurs (WIDTH>=2 enforced by range).

Reset
REQ-027 rst_n=0 SHALL immediately clear carry_q, sh, cnt, sum_word, cout_word, done, busy (and ovf when present) to 0.
REQ-028 Reset mid-word SHALL discard the partial word with no done pulse.
REQ-029 C and S SHALL be unaffected by reset.

Configuration
REQ-030 Macro FA_CS303_OVF_EN defined: extra output ovf (1b, after busy), registered with sum_word, equal to carry into MSB XOR carry out of MSB (signed overflow) of the completed word.
REQ-031 Macro undefined: ovf port and its logic are absent; all other behaviour identical.

Verification
REQ-032 Combinational sweep of all 8 xyz vectors, 10 time units apart, clk/rst_n idle -> (C,S): 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
REQ-033 WIDTH=8, serial 0x5A + 0x3C, start on bit 0 with z=0, en every cycle -> sum_word=0x96, cout_word=0, done one cycle, ovf=1.
REQ-034 Serial 0xFF + 0x01, z=0 -> sum_word=0x00, cout_word=1, ovf=0; then 0x00+0x00 with start z=1 -> sum_word=0x01, cout_word=0.
REQ-035 0x5A + 0x3C with en deasserted for 3 cycles after bit 3 -> same result as REQ-033, done only after 8th accepted bit.
REQ-036 rst_n pulsed low after bit 4 of a word -> all registers 0 immediately, no done; following full word computes correctly from bit 0.
REQ-037 start reasserted after bit 5 -> new word result only, single done pulse.
